// File: rtl/mux_sched_pkg.sv
// rtl/mux_sched_pkg.sv - shared types, defaults and helpers for the round-robin mux scheduler
package mux_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_BURST  = 4;

    // Round-robin successor of a channel index.
    function automatic int unsigned next_ptr(input int unsigned cur, input int unsigned num_ch);
        return (cur + 32'd1) % num_ch;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at ptr
module rr_picker #(
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester to ptr wins;
    // NUM_CH is a power of two, so the SEL_W-bit add wraps for free.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin burst scheduler with registered valid/ready output stage
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [NUM_CH-1:0]            req_valid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_CH-1:0]            req_ready_o,
    output logic [SEL_W-1:0]             sel_o,
    output logic [NUM_CH-1:0]            grant_o,
    output logic                         out_valid_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    input  logic                         out_ready_i,
    output logic                         busy_o
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    sched_state_e          state_q, state_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_CH-1:0]     grant_q, grant_d;
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;

    logic                  pick_found;
    logic [SEL_W-1:0]      pick_idx;
    logic                  cur_valid;
    logic                  can_take;
    logic                  accept;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] cur_data;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cur_valid = req_valid_i[sel_q];
    assign cur_data  = req_data_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
    assign can_take  = (state_q == BURST) & (~ov_q | out_ready_i);
    assign accept    = cur_valid & can_take;
    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ov_d    = ov_q;
        od_d    = od_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    sel_d   = pick_idx;
                    grant_d = NUM_CH'(1) << pick_idx;
                end
            end
            BURST: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Burst ends on its last accepted beat or when the owner abandons the grant.
                if (!cur_valid || (accept && last_beat)) begin
                    state_d = IDLE;
                    ptr_d   = SEL_W'(next_ptr(32'(sel_q), NUM_CH));
                    cnt_d   = '0;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output register runs independently of the FSM so a pending beat drains after the grant ends.
        if (accept) begin
            ov_d = 1'b1;
            od_d = cur_data;
        end else if (out_ready_i) begin
            ov_d = 1'b0;
        end
    end

    assign req_ready_o = can_take ? (NUM_CH'(1) << sel_q) : '0;
    assign sel_o       = sel_q;
    assign grant_o     = grant_q;
    assign out_valid_o = ov_q;
    assign out_data_o  = od_q;
    assign busy_o      = (state_q == BURST);

    assert property (@(posedge clk_i) disable iff (arst_i) $onehot0(grant_o));
    assert property (@(posedge clk_i) disable iff (arst_i) (state_q == IDLE) |-> (grant_o == '0));
    assert property (@(posedge clk_i) disable iff (arst_i) (|req_ready_o) |-> busy_o);

endmodule
